mult_unit: RTL and testbench

- Multicycle shift-add multiplier. Responder side of the controller's multiply handshake.
- The control unit loads operands with LDA/LDQ and starts an operation with MULT_EN. This block sequences the WIDTH add/shift steps itself, then returns DONE and the product for write-back through the D_SEL mux.
- It sits in the arithmetic datapath next to the ALU and register file.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/mult_unit_if.sv | 23 ++
 rtl/mult_step.sv | 21 ++
 rtl/mult_unit.sv | 86 ++++++++
 tb/tb_mult_unit.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath constants: FSM encodings, default operand width
// and the D_SEL code that routes the multiplier product to write-back.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Write-back mux select codes seen by the register file.
  localparam logic [1:0] D_SEL_ALU  = 2'd0;
  localparam logic [1:0] D_SEL_DIN  = 2'd1;
  localparam logic [1:0] D_SEL_MULT = 2'd2;

  function automatic logic is_busy(input logic [1:0] st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Multiply handshake between the control unit (master) and mult_unit (slave).
interface mult_unit_if #(
  parameter int WIDTH = arith_pkg::ARITH_WIDTH
);
  logic               LDA;
  logic               LDQ;
  logic               MULT_EN;
  logic [WIDTH-1:0]   DIN;
  logic               BUSY;
  logic               DONE;
  logic [2*WIDTH-1:0] PRODUCT;
  logic               Z_FLAG;

  modport master (
    output LDA, LDQ, MULT_EN, DIN,
    input  BUSY, DONE, PRODUCT, Z_FLAG
  );

  modport slave (
    input  LDA, LDQ, MULT_EN, DIN,
    output BUSY, DONE, PRODUCT, Z_FLAG
  );
endinterface

// File: rtl/mult_step.sv
// One combinational shift-add step: conditionally add A to ACC at WIDTH+1 bits,
// then shift {sum,QW} right by one so the sum carry lands in ACC's MSB.
module mult_step #(
  parameter int WIDTH = arith_pkg::ARITH_WIDTH
) (
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] qw,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] qw_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, acc} + (qw[0] ? {1'b0, a_reg} : '0);
    acc_nxt = sum[WIDTH:1];
    qw_nxt  = {sum[0], qw[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_unit.sv
// Multicycle unsigned shift-add multiplier; runs WIDTH steps after MULT_EN,
// then pulses DONE for one cycle with PRODUCT = {ACC,QW}.
module mult_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH,
  parameter int CNT_W = 4
) (
  input logic          CLK,
  input logic          RST,
  mult_unit_if.slave   bus
);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_reg, q_reg, acc, qw;
  logic [WIDTH-1:0] acc_step, qw_step;
  logic [CNT_W-1:0] cnt;
  logic             z_reg;
  logic             last_step;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .a_reg   (a_reg),
    .acc     (acc),
    .qw      (qw),
    .acc_nxt (acc_step),
    .qw_nxt  (qw_step)
  );

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.MULT_EN) state_nxt = ST_RUN;
      ST_RUN:  if (last_step)   state_nxt = ST_FIN;
      ST_FIN:                   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY = is_busy(state);
    bus.DONE = (state == ST_FIN);
  end

  // The carry bit C is always zero after a shift, so it is folded into the
  // WIDTH+1 bit sum inside mult_step rather than held in a register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
      qw    <= '0;
      cnt   <= '0;
      z_reg <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.LDA) a_reg <= bus.DIN;
          if (bus.LDQ) q_reg <= bus.DIN;
          if (bus.MULT_EN) begin
            acc <= '0;
            qw  <= q_reg;
            cnt <= '0;
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          qw  <= qw_step;
          cnt <= cnt + 1'b1;
          if (last_step) z_reg <= ({acc_step, qw_step} == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.PRODUCT = {acc, qw};
  assign bus.Z_FLAG  = z_reg;

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit (WIDTH=8).
module tb_mult_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_unit_if #(.WIDTH(8)) bus ();

  mult_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] q);
    bus.LDA = 1'b1; bus.DIN = a; tick();
    bus.LDA = 1'b0; bus.LDQ = 1'b1; bus.DIN = q; tick();
    bus.LDQ = 1'b0;
  endtask

  // Start one operation and watch it to completion. k counts edges after the
  // start edge E0; DONE must appear at k=8 and BUSY for 9 samples.
  task automatic run_op(input string tag, input logic [15:0] exp_p,
                        input logic exp_z, input bit junk);
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    logic [15:0] p_at_done = 16'hxxxx;
    logic        z_at_done = 1'bx;
    bus.MULT_EN = 1'b1;
    tick();
    bus.MULT_EN = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      if (junk && k >= 1 && k <= 3) begin
        bus.LDA = 1'b1; bus.LDQ = 1'b1; bus.DIN = 8'h77; bus.MULT_EN = 1'b1;
      end else if (junk && k == 4) begin
        bus.LDA = 1'b0; bus.LDQ = 1'b0; bus.MULT_EN = 1'b0;
      end
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at   = k;
          p_at_done = bus.PRODUCT;
          z_at_done = bus.Z_FLAG;
        end
      end
    end
    chk({tag, ".done_at"}, done_at, 8);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".busy_cnt"}, busy_cnt, 9);
    chk({tag, ".product"}, p_at_done, exp_p);
    chk({tag, ".z"}, z_at_done, exp_z);
    chk({tag, ".hold"}, bus.PRODUCT, exp_p);
  endtask

  initial begin
    int d[3];
    int nd;
    bus.LDA = 1'b0; bus.LDQ = 1'b0; bus.MULT_EN = 1'b0; bus.DIN = '0;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("rst.busy", bus.BUSY, 0);
    chk("rst.done", bus.DONE, 0);
    chk("rst.product", bus.PRODUCT, 0);
    chk("rst.z", bus.Z_FLAG, 1);

    load(8'd13, 8'd11);
    run_op("13x11", 16'h008F, 1'b0, 1'b0);

    load(8'hFF, 8'hFF);
    run_op("ffxff", 16'hFE01, 1'b0, 1'b0);

    load(8'h00, 8'h5A);
    run_op("0x5a", 16'h0000, 1'b1, 1'b0);
    load(8'h01, 8'h01);
    chk("load.hold", bus.PRODUCT, 16'h0000);
    run_op("1x1", 16'h0001, 1'b0, 1'b0);

    load(8'd3, 8'd4);
    run_op("junk", 16'h000C, 1'b0, 1'b1);
    run_op("rerun", 16'h000C, 1'b0, 1'b0);

    // LDQ together with start: QW uses the old Q_REG (4), new Q applies next run.
    bus.LDQ = 1'b1; bus.DIN = 8'd5;
    run_op("ldq_start", 16'h000C, 1'b0, 1'b0);
    bus.LDQ = 1'b0;
    run_op("ldq_next", 16'h000F, 1'b0, 1'b0);

    load(8'd3, 8'd5);
    bus.MULT_EN = 1'b1; tick(); bus.MULT_EN = 1'b0;
    tick(); tick(); tick();
    RST = 1'b1; tick(); RST = 1'b0;
    chk("midrst.busy", bus.BUSY, 0);
    chk("midrst.product", bus.PRODUCT, 0);
    chk("midrst.z", bus.Z_FLAG, 1);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.DONE) nd++;
      tick();
    end
    chk("midrst.nodone", nd, 0);
    load(8'd3, 8'd5);
    run_op("3x5", 16'h000F, 1'b0, 1'b0);

    load(8'd2, 8'd3);
    bus.MULT_EN = 1'b1;
    nd = 0;
    d = '{-1, -1, -1};
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (bus.DONE) begin
        if (nd < 3) d[nd] = k;
        nd++;
        chk("cont.product", bus.PRODUCT, 16'h0006);
      end else if (nd > 0 && !bus.BUSY) begin
        chk("cont.hold", bus.PRODUCT, 16'h0006);
      end
    end
    bus.MULT_EN = 1'b0;
    chk("cont.ndone", nd, 3);
    chk("cont.first", d[0], 9);
    chk("cont.gap1", d[1] - d[0], 10);
    chk("cont.gap2", d[2] - d[1], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
